// File: rtl/cdb_arbiter_if.sv
// Writeback bus between the three requesters (ALU, LSB, branch) and the CDB arbiter.
// A requester's entry transfers on any posedge where req_valid[i] and req_ready[i] are both 1;
// a requester keeps valid and data stable until that edge, and ready never depends on valid.
interface cdb_arbiter_if;
  logic             flush;
  logic [2:0]       req_valid;
  logic [2:0][4:0]  req_vregid;
  logic [2:0][31:0] req_val;
  logic [2:0]       req_ready;
  logic             cdb_en;
  logic [4:0]       cdb_vregid;
  logic [31:0]      cdb_val;
  logic             busy;
  logic [1:0]       dbg_ptr;
  logic [2:0][1:0]  dbg_count;

  modport master (
    output flush, req_valid, req_vregid, req_val,
    input  req_ready, cdb_en, cdb_vregid, cdb_val, busy, dbg_ptr, dbg_count
  );

  modport slave (
    input  flush, req_valid, req_vregid, req_val,
    output req_ready, cdb_en, cdb_vregid, cdb_val, busy, dbg_ptr, dbg_count
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three 2-entry writeback FIFOs drained one entry per cycle
// onto a registered broadcast bus, round-robin between non-empty FIFOs.
module cdb_arbiter #(
    parameter int NREQ  = 3,
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic rst,
    cdb_arbiter_if.slave bus
);

    typedef logic [36:0] entry_t;

    entry_t      mem   [NREQ][DEPTH];
    logic [1:0]  count [NREQ];
    logic        head  [NREQ];
    logic        tail  [NREQ];
    logic [1:0]  ptr, ptr_next;
    logic        grant_any;
    logic [1:0]  grant_idx;
    logic [NREQ-1:0] elig, push, pop;
    logic        cdb_en_q;
    logic [4:0]  cdb_vregid_q;
    logic [31:0] cdb_val_q;

    function automatic logic [1:0] wrap3(input logic [2:0] s);
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // Ready looks only at the start-of-cycle count, so a pop never frees a slot for a same-cycle push.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i]          = (count[i] != 2'd0);
            bus.req_ready[i] = (count[i] < 2'(DEPTH)) && !rst && !bus.flush;
            push[i]          = bus.req_valid[i] && bus.req_ready[i];
        end
    end

    // Walk the search order backwards so the first eligible FIFO after ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            logic [1:0] idx;
            idx = wrap3({1'b0, ptr} + 3'(k));
            if (elig[idx] && !bus.flush) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            pop[i] = grant_any && (grant_idx == 2'(i));
        end
    end

    always_comb begin
        ptr_next = ptr;
        if (bus.flush)      ptr_next = 2'd0;
        else if (grant_any) ptr_next = wrap3({1'b0, grant_idx} + 3'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= 2'd0;
            cdb_en_q     <= 1'b0;
            cdb_vregid_q <= 5'd0;
            cdb_val_q    <= 32'd0;
            for (int i = 0; i < NREQ; i++) begin
                count[i] <= 2'd0;
                head[i]  <= 1'b0;
                tail[i]  <= 1'b0;
            end
        end else begin
            ptr      <= ptr_next;
            cdb_en_q <= grant_any;
            if (grant_any) begin
                {cdb_vregid_q, cdb_val_q} <= mem[grant_idx][head[grant_idx]];
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.flush) begin
                    count[i] <= 2'd0;
                    head[i]  <= 1'b0;
                    tail[i]  <= 1'b0;
                end else begin
                    if (push[i]) tail[i] <= ~tail[i];
                    if (pop[i])  head[i] <= ~head[i];
                    case ({push[i], pop[i]})
                        2'b10:   count[i] <= count[i] + 2'd1;
                        2'b01:   count[i] <= count[i] - 2'd1;
                        default: count[i] <= count[i];
                    endcase
                end
            end
        end
    end

    // Storage carries no reset; count/pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) mem[i][tail[i]] <= {bus.req_vregid[i], bus.req_val[i]};
        end
    end

    always_comb begin
        bus.cdb_en     = cdb_en_q;
        bus.cdb_vregid = cdb_vregid_q;
        bus.cdb_val    = cdb_val_q;
        bus.dbg_ptr    = ptr;
        bus.busy       = cdb_en_q;
        for (int i = 0; i < NREQ; i++) begin
            bus.busy         = bus.busy || (count[i] != 2'd0);
            bus.dbg_count[i] = count[i];
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic checked
// cycle by cycle against a queue-based model of the arbitration rules.
module tb_cdb_arbiter;
  logic clk;
  logic rst;
  cdb_arbiter_if bus ();

  cdb_arbiter #(.NREQ(3), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // stimulus state
  logic        p_v   [3];
  logic [4:0]  p_vid [3];
  logic [31:0] p_val [3];
  logic        p_flush;
  logic [2:0]  acc;

  // reference model
  logic [36:0] mq [3][$];
  int          mptr;
  logic        m_en;
  logic [4:0]  m_vid;
  logic [31:0] m_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mq[i].delete();
    mptr  = 0;
    m_en  = 1'b0;
    m_vid = 5'd0;
    m_val = 32'd0;
    acc   = 3'b000;
  endtask

  // One cycle: drive at posedge+1, check at negedge, advance model, return at posedge+1.
  task automatic step();
    logic [2:0] exp_rdy;
    logic       any;
    logic       found;
    logic [36:0] e;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid[i]  = p_v[i];
      bus.req_vregid[i] = p_vid[i];
      bus.req_val[i]    = p_val[i];
    end
    bus.flush = p_flush;
    @(negedge clk);
    any = m_en;
    for (int i = 0; i < 3; i++) begin
      exp_rdy[i] = (mq[i].size() < 2) && !p_flush;
      check($sformatf("ready%0d", i), bus.req_ready[i], exp_rdy[i]);
      check($sformatf("count%0d", i), bus.dbg_count[i], mq[i].size());
      if (mq[i].size() != 0) any = 1'b1;
    end
    check("cdb_en", bus.cdb_en, m_en);
    check("cdb_vregid", bus.cdb_vregid, m_vid);
    check("cdb_val", bus.cdb_val, m_val);
    check("busy", bus.busy, any);
    check("ptr", bus.dbg_ptr, mptr);
    if (p_flush) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      m_en = 1'b0;
      mptr = 0;
      acc  = 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) acc[i] = p_v[i] && exp_rdy[i];
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (mptr + k) % 3;
        if (!found && mq[idx].size() > 0) begin
          found = 1'b1;
          e     = mq[idx].pop_front();
          m_vid = e[36:32];
          m_val = e[31:0];
          mptr  = (idx + 1) % 3;
        end
      end
      m_en = found;
      for (int i = 0; i < 3; i++) if (acc[i]) mq[i].push_back({p_vid[i], p_val[i]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < 3; i++) p_v[i] = 1'b0;
    p_flush = 1'b0;
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    // reset
    rst = 1'b1;
    p_flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      p_v[i] = 1'b0; p_vid[i] = 5'd0; p_val[i] = 32'd0;
    end
    bus.flush = 1'b0;
    bus.req_valid = '0;
    bus.req_vregid = '0;
    bus.req_val = '0;
    model_reset();
    #1;
    check("rst_cdb_en", bus.cdb_en, 1'b0);
    check("rst_ready", bus.req_ready, 3'b000);
    check("rst_busy", bus.busy, 1'b0);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", bus.req_ready, 3'b111);

    // single writeback on port 0
    p_v[0] = 1'b1; p_vid[0] = 5'd5; p_val[0] = 32'hDEADBEEF;
    step();
    p_v[0] = 1'b0;
    step();
    check("single_en", bus.cdb_en, 1'b1);
    check("single_vid", bus.cdb_vregid, 5'd5);
    check("single_val", bus.cdb_val, 32'hDEADBEEF);
    step();
    check("single_en_drop", bus.cdb_en, 1'b0);
    check("single_busy_drop", bus.busy, 1'b0);

    // contention from ptr=0 after a flush
    p_flush = 1'b1; step(); p_flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      p_v[i] = 1'b1; p_vid[i] = 5'(i + 1); p_val[i] = 32'h100 + 32'(i);
    end
    step();
    for (int i = 0; i < 3; i++) p_v[i] = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cont_en%0d", i), bus.cdb_en, 1'b1);
      check($sformatf("cont_vid%0d", i), bus.cdb_vregid, 5'(i + 1));
      step();
    end
    check("cont_end_en", bus.cdb_en, 1'b0);
    check("cont_end_ptr", bus.dbg_ptr, 2'd0);

    // port 1 streaming alone: drained every cycle, never fills
    for (int c = 0; c < 8; c++) begin
      p_v[1] = 1'b1; p_vid[1] = 5'(c + 10); p_val[1] = $urandom;
      step();
      check("stream_acc", acc[1], 1'b1);
    end
    idle(3);

    // FIFO 2 full while it is being popped: push rejected, count 2 -> 1
    p_flush = 1'b1; step(); p_flush = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        p_v[i] = 1'b1; p_vid[i] = 5'(8 * r + i); p_val[i] = $urandom;
      end
      step();
    end
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    p_v[2] = 1'b1; p_vid[2] = 5'd30; p_val[2] = 32'hC0FFEE00;
    step();
    check("full_ready2", bus.req_ready[2], 1'b0);
    check("full_count2", bus.dbg_count[2], 2'd2);
    step();
    check("full_pop_count2", bus.dbg_count[2], 2'd1);
    idle(6);

    // flush with entries pending and a simultaneous port-0 valid
    for (int i = 0; i < 3; i++) begin
      p_v[i] = 1'b1; p_vid[i] = 5'(20 + i); p_val[i] = $urandom;
    end
    step(); step();
    p_flush = 1'b1; p_v[0] = 1'b1; p_vid[0] = 5'd31;
    step();
    p_flush = 1'b0;
    for (int i = 0; i < 3; i++) p_v[i] = 1'b0;
    check("flush_en", bus.cdb_en, 1'b0);
    check("flush_busy", bus.busy, 1'b0);
    check("flush_count0", bus.dbg_count[0], 2'd0);
    idle(3);

    // random traffic with valid held until accepted, occasional flush
    acc = 3'b000;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!p_v[i] || acc[i]) begin
          p_v[i]   = ($urandom_range(0, 3) != 0);
          p_vid[i] = 5'($urandom);
          p_val[i] = $urandom;
        end
      end
      p_flush = ($urandom_range(0, 49) == 0);
      step();
    end
    idle(6);

    // asynchronous reset while a broadcast is on the bus
    p_v[1] = 1'b1; p_vid[1] = 5'd9; p_val[1] = 32'h12345678;
    step();
    p_v[1] = 1'b0;
    step();
    check("pre_rst_en", bus.cdb_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_en", bus.cdb_en, 1'b0);
    check("arst_vid", bus.cdb_vregid, 5'd0);
    check("arst_val", bus.cdb_val, 32'd0);
    check("arst_ready", bus.req_ready, 3'b000);
    check("arst_busy", bus.busy, 1'b0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("arst_release_ready", bus.req_ready, 3'b111);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
